// File: rtl/instr_decode_if.sv
// Connections of the decode stage: fetch word and handshake, register write-back,
// and the registered ID/EX slot handed to execute.
interface instr_decode_if #(
    parameter int REG_ADDR_W = 5
);
    logic [63:0]           reg_if_id;
    logic                  if_valid;
    logic                  flush;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [31:0]           wb_data;
    logic                  stall;
    logic                  jump_taken;
    logic [31:0]           jump_target;
    logic                  ex_valid;
    logic [31:0]           ex_pc;
    logic [31:0]           ex_rs_val;
    logic [31:0]           ex_rt_val;
    logic [31:0]           ex_imm;
    logic [31:0]           ex_br_target;
    logic [4:0]            ex_rs;
    logic [4:0]            ex_rt;
    logic [4:0]            ex_rd;
    logic [9:0]            ex_ctrl;
    logic                  illegal;

    modport master (
        output reg_if_id, if_valid, flush, wb_we, wb_addr, wb_data,
        input  stall, jump_taken, jump_target, ex_valid, ex_pc, ex_rs_val, ex_rt_val,
               ex_imm, ex_br_target, ex_rs, ex_rt, ex_rd, ex_ctrl, illegal
    );

    modport slave (
        input  reg_if_id, if_valid, flush, wb_we, wb_addr, wb_data,
        output stall, jump_taken, jump_target, ex_valid, ex_pc, ex_rs_val, ex_rt_val,
               ex_imm, ex_br_target, ex_rs, ex_rt, ex_rd, ex_ctrl, illegal
    );
endinterface

// File: rtl/instr_decode.sv
// MIPS32-subset decode stage: register file, control decode, load-use stall
// detection and the ID/EX pipeline register.
module instr_decode #(
    parameter int REG_ADDR_W = 5,
    parameter bit WB_BYPASS  = 1'b1
) (
    input logic           clk,
    input logic           reset,
    instr_decode_if.slave dif
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [31:0] pc, instr, pc_plus4, imm;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [REG_ADDR_W-1:0] rs_idx, rt_idx;

    assign pc       = dif.reg_if_id[63:32];
    assign instr    = dif.reg_if_id[31:0];
    assign pc_plus4 = pc + 32'd4;
    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign imm      = {{16{instr[15]}}, instr[15:0]};
    assign rs_idx   = rs[REG_ADDR_W-1:0];
    assign rt_idx   = rt[REG_ADDR_W-1:0];

    logic [NUM_REGS-1:0][31:0] rf;
    logic [31:0] rs_val, rt_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf <= '0;
        end else if (dif.wb_we && dif.wb_addr != '0) begin
            rf[dif.wb_addr] <= dif.wb_data;
        end
    end

    // r0 is forced to zero on read, so a write to it can never be observed.
    always_comb begin
        rs_val = rf[rs_idx];
        if (WB_BYPASS && dif.wb_we && dif.wb_addr == rs_idx) rs_val = dif.wb_data;
        if (rs_idx == '0) rs_val = '0;
    end

    always_comb begin
        rt_val = rf[rt_idx];
        if (WB_BYPASS && dif.wb_we && dif.wb_addr == rt_idx) rt_val = dif.wb_data;
        if (rt_idx == '0) rt_val = '0;
    end

    logic [9:0] ctrl;
    logic [4:0] dest;
    logic       is_illegal, is_jump, uses_rt;

    // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op}
    always_comb begin
        ctrl       = '0;
        dest       = '0;
        is_illegal = 1'b0;
        is_jump    = 1'b0;
        uses_rt    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                uses_rt = 1'b1;
                if (instr != '0) begin
                    dest = rd;
                    case (funct)
                        6'h20:   ctrl = {6'b100000, ALU_ADD};
                        6'h22:   ctrl = {6'b100000, ALU_SUB};
                        6'h24:   ctrl = {6'b100000, ALU_AND};
                        6'h25:   ctrl = {6'b100000, ALU_OR};
                        6'h2A:   ctrl = {6'b100000, ALU_SLT};
                        default: begin
                            dest       = '0;
                            is_illegal = 1'b1;
                        end
                    endcase
                end
            end
            OP_ADDI: begin
                ctrl = {6'b100010, ALU_ADD};
                dest = rt;
            end
            OP_LW: begin
                ctrl = {6'b110110, ALU_ADD};
                dest = rt;
            end
            OP_SW: begin
                ctrl    = {6'b001010, ALU_ADD};
                uses_rt = 1'b1;
            end
            OP_BEQ: begin
                ctrl    = {6'b000001, ALU_SUB};
                uses_rt = 1'b1;
            end
            OP_J:    is_jump = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

    logic load_use, issue;

    // The bubble inserted by a stall clears ex_valid, so each hazard stalls once.
    assign load_use = dif.ex_valid & dif.ex_ctrl[8] & (dif.ex_rd != 5'd0) &
                      ((dif.ex_rd == rs) | (uses_rt & (dif.ex_rd == rt)));

    assign dif.stall       = dif.if_valid & ~dif.flush & load_use;
    assign dif.jump_taken  = dif.if_valid & ~dif.flush & ~load_use & is_jump;
    assign dif.jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign issue           = dif.if_valid & ~dif.flush & ~load_use & ~is_jump;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dif.ex_valid     <= 1'b0;
            dif.ex_pc        <= '0;
            dif.ex_rs_val    <= '0;
            dif.ex_rt_val    <= '0;
            dif.ex_imm       <= '0;
            dif.ex_br_target <= '0;
            dif.ex_rs        <= '0;
            dif.ex_rt        <= '0;
            dif.ex_rd        <= '0;
            dif.ex_ctrl      <= '0;
            dif.illegal      <= 1'b0;
        end else begin
            dif.ex_pc    <= pc;
            dif.ex_valid <= issue;
            if (issue) begin
                dif.ex_rs_val    <= rs_val;
                dif.ex_rt_val    <= rt_val;
                dif.ex_imm       <= imm;
                dif.ex_br_target <= pc_plus4 + {imm[29:0], 2'b00};
                dif.ex_rs        <= rs;
                dif.ex_rt        <= rt;
                dif.ex_rd        <= dest;
                dif.ex_ctrl      <= ctrl;
                dif.illegal      <= is_illegal;
            end else begin
                dif.ex_rs_val    <= '0;
                dif.ex_rt_val    <= '0;
                dif.ex_imm       <= '0;
                dif.ex_br_target <= '0;
                dif.ex_rs        <= '0;
                dif.ex_rt        <= '0;
                dif.ex_rd        <= '0;
                dif.ex_ctrl      <= '0;
                dif.illegal      <= 1'b0;
            end
        end
    end
endmodule
